// File: rtl/iomem_timer_if.sv
// iomem bus bundle between the SoC initiator and the timer responder.
interface iomem_timer_if;
  logic        iomem_valid;
  logic        iomem_ready;
  logic [3:0]  iomem_wstrb;
  logic [31:0] iomem_addr;
  logic [31:0] iomem_wdata;
  logic [31:0] iomem_rdata;

  modport master (
    output iomem_valid, iomem_wstrb, iomem_addr, iomem_wdata,
    input  iomem_ready, iomem_rdata
  );

  modport slave (
    input  iomem_valid, iomem_wstrb, iomem_addr, iomem_wdata,
    output iomem_ready, iomem_rdata
  );
endinterface

// File: rtl/iomem_timer.sv
// Down-counting timer / interrupt source on the iomem bus.
// One 256-byte window: CTRL, RELOAD, COUNT, STATUS (sticky EXPIRED, W1C), PRESC.
// Ready is a registered one-cycle pulse; a request that keeps valid high after
// its ack is not acked again until valid drops, so a held request is never
// serviced twice. rdata is zero whenever ready is low so responders can be ORed.
module iomem_timer #(
  parameter logic [31:0] BASE_ADDR = 32'h0300_0000,
  parameter int unsigned WIDTH     = 32,
  parameter int unsigned PRESC_W   = 16
) (
  input  logic          clk,
  input  logic          reset,
  iomem_timer_if.slave  bus,
  output logic          irq
);

  localparam logic [5:0] W_CTRL   = 6'd0;
  localparam logic [5:0] W_RELOAD = 6'd1;
  localparam logic [5:0] W_COUNT  = 6'd2;
  localparam logic [5:0] W_STATUS = 6'd3;
  localparam logic [5:0] W_PRESC  = 6'd4;

  // Replace only the strobed bytes of cur with the matching bytes of wd.
  function automatic logic [31:0] merge_bytes(input logic [31:0] cur,
                                              input logic [31:0] wd,
                                              input logic [3:0]  strb);
    logic [31:0] res;
    res = cur;
    for (int b = 0; b < 4; b++) begin
      if (strb[b]) begin
        res[8*b +: 8] = wd[8*b +: 8];
      end else begin
        res[8*b +: 8] = cur[8*b +: 8];
      end
    end
    return res;
  endfunction

  logic               ready_q, ready_d;
  logic               ack_done_q, ack_done_d;
  logic [31:0]        rdata_q, rdata_d;
  logic               irq_q, irq_d;
  logic               en_q, en_d;
  logic               auto_q, auto_d;
  logic               irq_en_q, irq_en_d;
  logic               expired_q, expired_d;
  logic [WIDTH-1:0]   reload_q, reload_d;
  logic [WIDTH-1:0]   count_q, count_d;
  logic [PRESC_W-1:0] presc_q, presc_d;
  logic [PRESC_W-1:0] pcnt_q, pcnt_d;

  logic               sel_s;
  logic               acc_s;
  logic               wr_s;
  logic               tick_s;
  logic [5:0]         word_s;
  logic [31:0]        rd_s;
  logic [31:0]        wmerge_s;
  logic               addr_lsb_unused_s;

  // Byte lane bits of the address do not select anything.
  assign addr_lsb_unused_s = ^bus.iomem_addr[1:0];

  // Window decode, access qualification and pre-write read mux.
  always_comb begin
    sel_s  = bus.iomem_valid && (bus.iomem_addr[31:8] == BASE_ADDR[31:8]);
    acc_s  = sel_s && !ready_q && !ack_done_q;
    wr_s   = acc_s && (bus.iomem_wstrb != 4'b0000);
    word_s = bus.iomem_addr[7:2];
    rd_s   = 32'h0000_0000;
    case (word_s)
      W_CTRL:   rd_s[2:0]         = {irq_en_q, auto_q, en_q};
      W_RELOAD: rd_s[WIDTH-1:0]   = reload_q;
      W_COUNT:  rd_s[WIDTH-1:0]   = count_q;
      W_STATUS: rd_s[0]           = expired_q;
      W_PRESC:  rd_s[PRESC_W-1:0] = presc_q;
      default:  rd_s              = 32'h0000_0000;
    endcase
    // Merging onto the read view gives strobe-correct, width-limited writes.
    wmerge_s = merge_bytes(rd_s, bus.iomem_wdata, bus.iomem_wstrb);
  end

  // Next state: prescaler, tick handling, then bus writes which take priority.
  always_comb begin
    en_d      = en_q;
    auto_d    = auto_q;
    irq_en_d  = irq_en_q;
    reload_d  = reload_q;
    presc_d   = presc_q;
    count_d   = count_q;
    expired_d = expired_q;

    tick_s = en_q && (pcnt_q == presc_q);
    if (!en_q || tick_s) begin
      pcnt_d = '0;
    end else begin
      pcnt_d = pcnt_q + PRESC_W'(1);
    end

    // W1C first so that an expiry on the same edge wins.
    if (wr_s && (word_s == W_STATUS) && bus.iomem_wstrb[0] && bus.iomem_wdata[0]) begin
      expired_d = 1'b0;
    end else begin
      expired_d = expired_q;
    end

    if (tick_s) begin
      if (count_q != '0) begin
        count_d = count_q - WIDTH'(1);
      end else begin
        expired_d = 1'b1;
        if (auto_q) begin
          count_d = reload_q;
        end else begin
          count_d = count_q;
          en_d    = 1'b0;
        end
      end
    end else begin
      count_d = count_q;
    end

    // Bus writes override the tick's COUNT update and the one-shot EN clear.
    if (wr_s) begin
      case (word_s)
        W_CTRL: begin
          en_d     = wmerge_s[0];
          auto_d   = wmerge_s[1];
          irq_en_d = wmerge_s[2];
        end
        W_RELOAD: reload_d = wmerge_s[WIDTH-1:0];
        W_COUNT:  count_d  = wmerge_s[WIDTH-1:0];
        W_PRESC: begin
          presc_d = wmerge_s[PRESC_W-1:0];
          pcnt_d  = '0;
        end
        default: reload_d = reload_q;
      endcase
    end else begin
      reload_d = reload_q;
    end

    ready_d    = acc_s;
    ack_done_d = sel_s && (ack_done_q || acc_s);
    if (acc_s) begin
      rdata_d = rd_s;
    end else begin
      rdata_d = 32'h0000_0000;
    end
    irq_d = expired_d && irq_en_d;
  end

  // State registers with synchronous reset; a pending access is dropped.
  always_ff @(posedge clk) begin
    if (reset) begin
      ready_q    <= 1'b0;
      ack_done_q <= 1'b0;
      rdata_q    <= 32'h0000_0000;
      irq_q      <= 1'b0;
      en_q       <= 1'b0;
      auto_q     <= 1'b0;
      irq_en_q   <= 1'b0;
      expired_q  <= 1'b0;
      reload_q   <= '0;
      count_q    <= '0;
      presc_q    <= '0;
      pcnt_q     <= '0;
    end else begin
      ready_q    <= ready_d;
      ack_done_q <= ack_done_d;
      rdata_q    <= rdata_d;
      irq_q      <= irq_d;
      en_q       <= en_d;
      auto_q     <= auto_d;
      irq_en_q   <= irq_en_d;
      expired_q  <= expired_d;
      reload_q   <= reload_d;
      count_q    <= count_d;
      presc_q    <= presc_d;
      pcnt_q     <= pcnt_d;
    end
  end

  assign bus.iomem_ready = ready_q;
  assign bus.iomem_rdata = rdata_q;
  assign irq             = irq_q;

endmodule
